// File: rtl/decode_stage_p_if.sv
// ---------------------------------------------------------------------------
// decode_stage_p_if
//   Bundles every non-clock/reset signal of the decode stage.
//   master : fetch/control/writeback side (drives instruction, control,
//            writeback and forward inputs; observes operands and redirect)
//   slave  : the decode stage itself
//
//   Signals (DW = datapath width, >= 16):
//     instr[15:0], instr_valid, stall, flush           instruction + pipe control
//     wr_en, wr_addr[2:0], wr_data[DW-1:0]             writeback port
//     fwd_en, fwd_addr[2:0], fwd_data[DW-1:0]          EX-stage forward
//     next_pc[DW-1:0]                                  PC of following instr
//     sign_ext_sel[1:0], zero_ext8, data2_sel, load_r7 operand selection
//     branch, br_cond[1:0], jump, pc_base_sel,
//     br_imm_sel                                       control-flow resolution
//     data1_q, data2_q, valid_q                        registered D/E outputs
//     true_pc, redirect                                combinational fetch steer
//
//   Flow control: valid_q qualifies data1_q/data2_q. There is no ready;
//   the downstream side holds the register with stall and kills it with
//   flush (flush beats stall). redirect is only ever raised for a valid,
//   non-stalled instruction.
// ---------------------------------------------------------------------------
interface decode_stage_p_if #(
    parameter int DW = 16
);
    logic [15:0]   instr;
    logic          instr_valid;
    logic          stall;
    logic          flush;
    logic          wr_en;
    logic [2:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          fwd_en;
    logic [2:0]    fwd_addr;
    logic [DW-1:0] fwd_data;
    logic [DW-1:0] next_pc;
    logic [1:0]    sign_ext_sel;
    logic          zero_ext8;
    logic          data2_sel;
    logic          load_r7;
    logic          branch;
    logic [1:0]    br_cond;
    logic          jump;
    logic          pc_base_sel;
    logic          br_imm_sel;
    logic [DW-1:0] data1_q;
    logic [DW-1:0] data2_q;
    logic          valid_q;
    logic [DW-1:0] true_pc;
    logic          redirect;

    modport master (
        output instr, instr_valid, stall, flush,
        output wr_en, wr_addr, wr_data,
        output fwd_en, fwd_addr, fwd_data,
        output next_pc, sign_ext_sel, zero_ext8, data2_sel, load_r7,
        output branch, br_cond, jump, pc_base_sel, br_imm_sel,
        input  data1_q, data2_q, valid_q, true_pc, redirect
    );

    modport slave (
        input  instr, instr_valid, stall, flush,
        input  wr_en, wr_addr, wr_data,
        input  fwd_en, fwd_addr, fwd_data,
        input  next_pc, sign_ext_sel, zero_ext8, data2_sel, load_r7,
        input  branch, br_cond, jump, pc_base_sel, br_imm_sel,
        output data1_q, data2_q, valid_q, true_pc, redirect
    );
endinterface

// File: rtl/decode_stage_p.sv
// ---------------------------------------------------------------------------
// decode_stage_p
//   Decode stage of the 16-bit-instruction CPU with a DW-wide datapath:
//   8-entry register file, two-level read bypass (EX forward over
//   writeback over array), immediate generation, branch/jump target
//   resolution and the decode/execute pipeline register.
//
//   Parameters
//     DW       datapath/register/PC width (>= 16)
//     RST_VAL  reset value of every register-file entry
//   Ports
//     clk      rising-edge clock
//     rst      asynchronous active-low reset
//     bus      decode_stage_p_if.slave (instruction, control, writeback,
//              forward, operands, redirect)
//
//   Timing: redirect/true_pc are combinational from the current inputs;
//   data1_q/data2_q/valid_q appear one edge later.
// ---------------------------------------------------------------------------
module decode_stage_p #(
    parameter int            DW      = 16,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    decode_stage_p_if.slave  bus
);

    // ---------------- state ----------------
    logic [DW-1:0] regs_q [8];
    logic [DW-1:0] data1_q, data1_d;
    logic [DW-1:0] data2_q, data2_d;
    logic          valid_q, valid_d;

    // ---------------- register addresses ----------------
    logic [2:0] rs_addr;
    logic [2:0] rt_addr;
    assign rs_addr = bus.instr[10:8];
    assign rt_addr = bus.instr[7:5];

    // Opcode bits are decoded upstream into the control inputs.
    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.instr[15:11];

    // ---------------- read bypass ----------------
    // Later assignment wins, so the EX forward overrides a same-cycle
    // writeback to the same register, which overrides the array.
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;

    always_comb begin
        rs_val = regs_q[rs_addr];
        if (bus.wr_en && (bus.wr_addr == rs_addr)) begin
            rs_val = bus.wr_data;
        end
        if (bus.fwd_en && (bus.fwd_addr == rs_addr)) begin
            rs_val = bus.fwd_data;
        end
    end

    always_comb begin
        rt_val = regs_q[rt_addr];
        if (bus.wr_en && (bus.wr_addr == rt_addr)) begin
            rt_val = bus.wr_data;
        end
        if (bus.fwd_en && (bus.fwd_addr == rt_addr)) begin
            rt_val = bus.fwd_data;
        end
    end

    // ---------------- immediates ----------------
    logic [DW-1:0] sx5;
    logic [DW-1:0] sx8;
    logic [DW-1:0] sx11;
    logic [DW-1:0] zext;
    logic [DW-1:0] imm;

    assign sx5  = {{(DW-5){bus.instr[4]}},   bus.instr[4:0]};
    assign sx8  = {{(DW-8){bus.instr[7]}},   bus.instr[7:0]};
    assign sx11 = {{(DW-11){bus.instr[10]}}, bus.instr[10:0]};
    assign zext = bus.zero_ext8 ? {{(DW-8){1'b0}}, bus.instr[7:0]}
                                : {{(DW-4){1'b0}}, bus.instr[3:0]};

    always_comb begin
        imm = sx5;
        case (bus.sign_ext_sel)
            2'b00:   imm = sx5;
            2'b01:   imm = sx8;
            2'b10:   imm = sx11;
            default: imm = zext;
        endcase
    end

    // ---------------- operands ----------------
    logic [DW-1:0] data1;
    logic [DW-1:0] data2;
    assign data1 = bus.load_r7   ? bus.next_pc : rs_val;
    assign data2 = bus.data2_sel ? imm         : rt_val;

    // ---------------- branch / jump resolution ----------------
    // The condition looks at the bypassed Rs value, not at data1, so a
    // link (load_r7) in the same instruction does not disturb it.
    logic cond;
    always_comb begin
        cond = 1'b0;
        case (bus.br_cond)
            2'b00:   cond = (rs_val == '0);
            2'b01:   cond = (rs_val != '0);
            2'b10:   cond = rs_val[DW-1];
            default: cond = ~rs_val[DW-1];
        endcase
    end

    logic [DW-1:0] target_base;
    logic [DW-1:0] target_off;
    logic [DW-1:0] target;
    assign target_base = bus.pc_base_sel ? bus.next_pc : rs_val;
    assign target_off  = bus.br_imm_sel  ? sx11        : sx8;
    assign target      = target_base + target_off;   // wraps modulo 2^DW

    // jump needs no condition, so jump+branch always redirects.
    logic redirect;
    assign redirect = bus.instr_valid & ~bus.stall & (bus.jump | (bus.branch & cond));

    assign bus.redirect = redirect;
    assign bus.true_pc  = redirect ? target : bus.next_pc;

    // ---------------- pipeline register next state ----------------
    // Flush only kills valid; the data fields are don't-care once invalid
    // so they are left alone.
    always_comb begin
        data1_d = data1_q;
        data2_d = data2_q;
        valid_d = valid_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (!bus.stall) begin
            data1_d = data1;
            data2_d = data2;
            valid_d = bus.instr_valid;
        end
    end

    // ---------------- sequential ----------------
    // Writeback is independent of stall/flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= RST_VAL;
            end
            data1_q <= '0;
            data2_q <= '0;
            valid_q <= 1'b0;
        end else begin
            if (bus.wr_en) begin
                regs_q[bus.wr_addr] <= bus.wr_data;
            end
            data1_q <= data1_d;
            data2_q <= data2_d;
            valid_q <= valid_d;
        end
    end

    assign bus.data1_q = data1_q;
    assign bus.data2_q = data2_q;
    assign bus.valid_q = valid_q;

endmodule

// File: tb/tb_decode_stage_p.sv
module tb_decode_stage_p;

    localparam logic [15:0] RST16 = 16'hA5A5;
    localparam logic [31:0] RST32 = 32'h5A5A_0001;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_p_if #(.DW(16)) b16 ();
    decode_stage_p_if #(.DW(32)) b32 ();

    decode_stage_p #(.DW(16), .RST_VAL(RST16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    decode_stage_p #(.DW(32), .RST_VAL(RST32)) dut32 (.clk(clk), .rst(rst), .bus(b32));

    // ---------------- scoreboard ----------------
    // which: 0 data1_q/16, 1 data2_q/16, 2 valid_q/16, 3 data1_q/32, 4 data2_q/32, 5 valid_q/32
    logic [31:0] exp_q[$];
    int          sel_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int which);
        case (which)
            0:       return {16'h0, b16.data1_q};
            1:       return {16'h0, b16.data2_q};
            2:       return {31'h0, b16.valid_q};
            3:       return b32.data1_q;
            4:       return b32.data2_q;
            default: return {31'h0, b32.valid_q};
        endcase
    endfunction

    task automatic push(input string tag, input int which, input logic [31:0] val);
        tag_q.push_back(tag);
        sel_q.push_back(which);
        exp_q.push_back(val);
    endtask

    task automatic check_sb();
        while (exp_q.size() > 0) begin
            check(tag_q.pop_front(), observe(sel_q.pop_front()), exp_q.pop_front());
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle16();
        b16.instr = '0; b16.instr_valid = 0; b16.stall = 0; b16.flush = 0;
        b16.wr_en = 0; b16.wr_addr = '0; b16.wr_data = '0;
        b16.fwd_en = 0; b16.fwd_addr = '0; b16.fwd_data = '0;
        b16.next_pc = '0; b16.sign_ext_sel = '0; b16.zero_ext8 = 0;
        b16.data2_sel = 0; b16.load_r7 = 0; b16.branch = 0; b16.br_cond = '0;
        b16.jump = 0; b16.pc_base_sel = 0; b16.br_imm_sel = 0;
    endtask

    task automatic idle32();
        b32.instr = '0; b32.instr_valid = 0; b32.stall = 0; b32.flush = 0;
        b32.wr_en = 0; b32.wr_addr = '0; b32.wr_data = '0;
        b32.fwd_en = 0; b32.fwd_addr = '0; b32.fwd_data = '0;
        b32.next_pc = '0; b32.sign_ext_sel = '0; b32.zero_ext8 = 0;
        b32.data2_sel = 0; b32.load_r7 = 0; b32.branch = 0; b32.br_cond = '0;
        b32.jump = 0; b32.pc_base_sel = 0; b32.br_imm_sel = 0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [2:0] ra;
        rst = 1'b0;
        idle16();
        idle32();
        step();
        step();

        // Reset state and combinational path during reset
        check("rst_valid16", {31'h0, b16.valid_q}, 32'h0);
        check("rst_data1_16", {16'h0, b16.data1_q}, 32'h0);
        check("rst_data2_16", {16'h0, b16.data2_q}, 32'h0);
        check("rst_valid32", {31'h0, b32.valid_q}, 32'h0);
        check("rst_data1_32", b32.data1_q, 32'h0);
        b16.next_pc = 16'h0040; b16.jump = 1; b16.instr_valid = 1;
        b16.pc_base_sel = 1; b16.br_imm_sel = 1; b16.instr = 16'h0010;
        #1;
        check("rst_comb_redirect", {31'h0, b16.redirect}, 32'h1);
        check("rst_comb_true_pc", {16'h0, b16.true_pc}, 32'h0050);
        idle16();
        rst = 1'b1;

        // Every register reads its reset value
        for (int r = 0; r < 8; r++) begin
            ra = 3'(r);
            b16.instr = {5'b0, ra, 8'h00};
            b16.instr_valid = 1;
            b32.instr = {5'b0, ra, 8'h00};
            push("rst_reg16", 0, {16'h0, RST16});
            push("rst_reg32", 3, RST32);
            step();
            check_sb();
        end

        // Bypass: forward beats writeback beats array
        idle16(); idle32();
        b16.wr_en = 1; b16.wr_addr = 3; b16.wr_data = 16'h0011;
        step();
        b16.wr_data = 16'h0022;
        b16.fwd_en = 1; b16.fwd_addr = 3; b16.fwd_data = 16'h0033;
        b16.instr = 16'h0300; b16.instr_valid = 1;
        push("byp_fwd_wins", 0, 32'h0033);
        push("byp_valid", 2, 32'h1);
        step(); check_sb();
        b16.wr_en = 0; b16.fwd_en = 0;
        push("byp_array_r3", 0, 32'h0022);
        step(); check_sb();
        b16.instr = 16'h05A0;
        b16.wr_en = 1; b16.wr_addr = 5; b16.wr_data = 16'h0055;
        b16.fwd_en = 1; b16.fwd_addr = 6; b16.fwd_data = 16'h0066;
        push("byp_wr_rs", 0, 32'h0055);
        push("byp_wr_rt", 1, 32'h0055);
        step(); check_sb();
        b16.wr_en = 0; b16.fwd_addr = 5;
        push("byp_fwd_rs", 0, 32'h0066);
        push("byp_fwd_rt", 1, 32'h0066);
        step(); check_sb();
        b16.fwd_en = 0; b16.instr_valid = 0;
        push("byp_arr_rs", 0, 32'h0055);
        push("byp_arr_rt", 1, 32'h0055);
        push("byp_invalid", 2, 32'h0);
        step(); check_sb();

        // Branch resolution
        idle16();
        b16.wr_en = 1; b16.wr_addr = 1; b16.wr_data = 16'h8000;
        step();
        b16.wr_en = 0;
        b16.instr = 16'h01FE; b16.branch = 1; b16.br_cond = 2'b10;
        b16.pc_base_sel = 1; b16.br_imm_sel = 0; b16.next_pc = 16'h0100;
        b16.instr_valid = 1;
        #1;
        check("br_ltz_redirect", {31'h0, b16.redirect}, 32'h1);
        check("br_ltz_true_pc", {16'h0, b16.true_pc}, 32'h00FE);
        b16.br_cond = 2'b11;
        #1;
        check("br_gez_redirect", {31'h0, b16.redirect}, 32'h0);
        check("br_gez_true_pc", {16'h0, b16.true_pc}, 32'h0100);
        b16.br_cond = 2'b10; b16.instr_valid = 0;
        #1;
        check("br_novalid_redirect", {31'h0, b16.redirect}, 32'h0);
        step();
        b16.instr_valid = 1; b16.instr = 16'h00FE; b16.br_cond = 2'b00;
        #1;
        check("br_eqz_redirect", {31'h0, b16.redirect}, 32'h0);
        b16.br_cond = 2'b01;
        #1;
        check("br_nez_redirect", {31'h0, b16.redirect}, 32'h1);
        check("br_nez_true_pc", {16'h0, b16.true_pc}, 32'h00FE);
        b16.instr = 16'h01FE; b16.br_cond = 2'b10; b16.pc_base_sel = 0;
        #1;
        check("br_rs_base_true_pc", {16'h0, b16.true_pc}, 32'h7FFE);
        step();

        // Jump target wrap and jump priority
        idle16();
        b16.next_pc = 16'hFFFE; b16.instr = 16'h0004; b16.jump = 1;
        b16.pc_base_sel = 1; b16.br_imm_sel = 1; b16.instr_valid = 1;
        #1;
        check("jmp_wrap_redirect", {31'h0, b16.redirect}, 32'h1);
        check("jmp_wrap_true_pc", {16'h0, b16.true_pc}, 32'h0002);
        b16.branch = 1; b16.br_cond = 2'b00;
        #1;
        check("jmp_over_br_redirect", {31'h0, b16.redirect}, 32'h1);
        b16.instr = 16'h07FC;
        #1;
        check("jmp_neg_true_pc", {16'h0, b16.true_pc}, 32'hFFFA);
        step();

        // Stall / flush
        idle16();
        b16.instr_valid = 1; b16.load_r7 = 1; b16.next_pc = 16'h1234;
        b16.data2_sel = 1; b16.sign_ext_sel = 2'b00; b16.instr = 16'h0010;
        push("sf_load_d1", 0, 32'h1234);
        push("sf_load_d2_sx5", 1, 32'hFFF0);
        push("sf_load_v", 2, 32'h1);
        step(); check_sb();
        b16.stall = 1; b16.next_pc = 16'h9999; b16.instr = 16'h001F; b16.jump = 1;
        b16.wr_en = 1; b16.wr_addr = 4; b16.wr_data = 16'h4444;
        #1;
        check("sf_stall_redirect", {31'h0, b16.redirect}, 32'h0);
        check("sf_stall_true_pc", {16'h0, b16.true_pc}, 32'h9999);
        push("sf_hold1_d1", 0, 32'h1234);
        push("sf_hold1_d2", 1, 32'hFFF0);
        push("sf_hold1_v", 2, 32'h1);
        step(); check_sb();
        b16.wr_en = 0;
        push("sf_hold2_d1", 0, 32'h1234);
        push("sf_hold2_v", 2, 32'h1);
        step(); check_sb();
        b16.flush = 1;
        push("sf_flush_stall_v", 2, 32'h0);
        push("sf_flush_stall_d1", 0, 32'h1234);
        step(); check_sb();
        b16.flush = 0; b16.stall = 0; b16.jump = 0; b16.load_r7 = 0;
        b16.data2_sel = 0; b16.instr = 16'h0400; b16.instr_valid = 1;
        push("sf_wb_during_stall", 0, 32'h4444);
        push("sf_resume_v", 2, 32'h1);
        step(); check_sb();
        b16.flush = 1; b16.instr = 16'h0100;
        push("sf_flush_v", 2, 32'h0);
        push("sf_flush_d1_kept", 0, 32'h4444);
        step(); check_sb();

        // DW=32 immediates and link
        idle16();
        b32.instr = 16'h0080; b32.sign_ext_sel = 2'b01; b32.data2_sel = 1; b32.instr_valid = 1;
        push("w32_sx8", 4, 32'hFFFFFF80);
        push("w32_valid", 5, 32'h1);
        step(); check_sb();
        b32.sign_ext_sel = 2'b11; b32.zero_ext8 = 1;
        push("w32_zx8", 4, 32'h00000080);
        step(); check_sb();
        b32.instr = 16'h008F; b32.zero_ext8 = 0;
        push("w32_zx4", 4, 32'h0000000F);
        step(); check_sb();
        b32.instr = 16'h0400; b32.sign_ext_sel = 2'b10;
        b32.load_r7 = 1; b32.next_pc = 32'h12345678;
        push("w32_sx11", 4, 32'hFFFFFC00);
        push("w32_link", 3, 32'h12345678);
        step(); check_sb();
        b32.next_pc = 32'hFFFFFFFE; b32.instr = 16'h0004; b32.jump = 1;
        b32.pc_base_sel = 1; b32.br_imm_sel = 1;
        #1;
        check("w32_wrap_true_pc", b32.true_pc, 32'h00000002);
        step();

        // Reset in the middle of a stall
        idle32();
        b16.flush = 0; b16.instr_valid = 1; b16.load_r7 = 1; b16.next_pc = 16'h7777;
        push("mr_load_d1", 0, 32'h7777);
        push("mr_load_v", 2, 32'h1);
        step(); check_sb();
        b16.stall = 1;
        #2;
        rst = 1'b0;
        #1;
        check("mr_valid", {31'h0, b16.valid_q}, 32'h0);
        check("mr_data1", {16'h0, b16.data1_q}, 32'h0);
        step();
        rst = 1'b1;
        idle16();
        b16.instr = 16'h0400; b16.instr_valid = 1;
        push("mr_reg4_reset", 0, {16'h0, RST16});
        step(); check_sb();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
